root_dispatch: RTL and testbench
================================

ROOT_DISPATCH -- requirements
Module: root_dispatch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command queue entries (power of 2, >=2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, meaning cycles root_in_valid is held high per issue (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 3, meaning idle cycles after each result before the next issue (>=2).
REQ-004 SHALL have parameter TIMEOUT, default 64, meaning maximum WAIT cycles before an aborted result.
REQ-005 SHALL have the following ports, clock and reset first:
  clk  in  1  single clock; all flops rising-edge.
  rst_n  in  1  asynchronous, active-low reset.
  cmd_valid  in  1  upstream command offered.
  cmd_ready  out  1  queue can accept; high when count < FIFO_DEPTH.
  cmd_data_1  in  10  radicand.
  cmd_data_2  in  3  root degree.
  root_in_valid  out  1  drive to root stage in_valid.
  root_in_data_1  out  10  drive to root stage in_data_1.
  root_in_data_2  out  3  drive to root stage in_data_2.
  root_out_valid  in  1  root stage out_valid; may stay high 2 cycles.
  root_out_data  in  20  root stage result.
  res_valid  out  1  result register full.
  res_ready  in  1  downstream accepts result.
  res_data  out  20  captured root result.
  res_err  out  1  result is a timeout abort.
  busy  out  1  state != IDLE or count != 0.

Function
REQ-006 SHALL push {cmd_data_1, cmd_data_2} into the FIFO on cycles with cmd_valid && cmd_ready.
REQ-007 SHALL derive cmd_ready from the registered count only; a push offered while full is not accepted even if a pop occurs that cycle.
REQ-008 SHALL handle simultaneous push and pop with count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-009 SHALL implement FSM states IDLE, DRIVE, WAIT, GAP.
REQ-010 IDLE -> DRIVE when count != 0 && res_valid == 0; same edge pops head into root_in_data_1/2 registers.
REQ-011 DRIVE SHALL hold root_in_valid = 1 for exactly HOLD_CYCLES cycles with root_in_data_1/2 stable, then -> WAIT with root_in_valid = 0.
REQ-012 root_in_data_1/2 SHALL stay unchanged from pop until the next pop.
REQ-013 WAIT SHALL capture on the first cycle root_out_valid == 1: res_data <= root_out_data, res_err <= 0, res_valid <= 1 next edge; -> GAP.
REQ-014 WAIT SHALL count cycles; on reaching TIMEOUT without root_out_valid: res_data <= 0, res_err <= 1, res_valid <= 1; -> GAP.
REQ-015 GAP SHALL wait until root_out_valid == 0, then count GAP_CYCLES cycles, then -> IDLE; root_out_valid high in any state other than WAIT is ignored.
REQ-016 res_valid SHALL clear on the edge where res_valid && res_ready; res_data/res_err hold until the next capture.
REQ-017 Issue-to-capture latency: minimum HOLD_CYCLES + 1 cycles from DRIVE entry; the result is visible one cycle after root_out_valid rises.
REQ-018 Commands SHALL be issued and results produced strictly in FIFO order, one outstanding command at a time.

Reset
REQ-019 rst_n low SHALL asynchronously force: state IDLE, FIFO pointers and count 0, cmd_ready 1, root_in_valid 0, root_in_data_1/2 0, res_valid 0, res_data 0, res_err 0, busy 0, all counters 0.
REQ-020 Reset asserted mid-operation SHALL discard queued commands and any in-flight result; no res_valid pulse follows reset release until a new command completes.

Verification
REQ-021 Single command: push (100, 2), root model returns 20'h0A000 with out_valid high 2 cycles -> root_in_valid high exactly 2 cycles with 100/2; one result res_data = 20'h0A000, res_err = 0.
REQ-022 Fill: push 5 commands back-to-back with the root model stalled -> cmd_ready low once count reaches 4 (after first pop, FIFO holds 4); the 6th push is refused while full.
REQ-023 Ordering: 3 commands, root model echoes {10'b0, data_1} -> res_data sequence matches push order; each issue is separated by >= GAP_CYCLES idle cycles after root_out_valid falls.
REQ-024 Timeout: root model never responds -> after 64 WAIT cycles res_valid = 1, res_err = 1, res_data = 0; next command then issues normally.
REQ-025 Backpressure: hold res_ready = 0 with 2 queued commands -> the second command is not issued until the first result is accepted.
REQ-026 Reset mid-WAIT: assert rst_n low during WAIT -> all outputs reach REQ-019 values immediately; a late root_out_valid after release produces no result.

Source files
------------

// File: rtl/root_dispatch.sv
// Command queue plus a single-outstanding issue sequencer for a root-extraction stage.
// Each command is held on the root interface for a fixed time, then one result or a timeout abort is captured.
module root_dispatch #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_data_1,
  input  logic [2:0]  cmd_data_2,
  output logic        root_in_valid,
  output logic [9:0]  root_in_data_1,
  output logic [2:0]  root_in_data_2,
  input  logic        root_out_valid,
  input  logic [19:0] root_out_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [19:0] res_data,
  output logic        res_err,
  output logic        busy
);

  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CMAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CMAX   = (TIMEOUT > CMAX_A) ? TIMEOUT : CMAX_A;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_GAP} state_t;

  logic [12:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gap_arm_q, gap_arm_d;
  logic          riv_q, riv_d;
  logic [9:0]    rid1_q, rid1_d;
  logic [2:0]    rid2_q, rid2_d;
  logic          res_valid_q, res_valid_d;
  logic [19:0]   res_data_q, res_data_d;
  logic          res_err_q, res_err_d;

  logic push, pop;
  logic [12:0] head;

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
  assign cmd_ready = (count_q < DEPTH_C);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0) && !res_valid_q;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_data_1, cmd_data_2};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_arm_d   = gap_arm_q;
    riv_d       = riv_q;
    rid1_d      = rid1_q;
    rid2_d      = rid2_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d          = S_DRIVE;
          riv_d            = 1'b1;
          {rid1_d, rid2_d} = head;
          cnt_d            = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT;
          riv_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (root_out_valid) begin
          res_valid_d = 1'b1;
          res_data_d  = root_out_data;
          res_err_d   = 1'b0;
          state_d     = S_GAP;
          cnt_d       = '0;
          gap_arm_d   = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          res_valid_d = 1'b1;
          res_data_d  = '0;
          res_err_d   = 1'b1;
          state_d     = S_GAP;
          cnt_d       = '0;
          gap_arm_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        // Counting starts on the first cycle the stage's valid is low; later re-assertions are ignored.
        if (gap_arm_q || !root_out_valid) begin
          gap_arm_d = 1'b1;
          if (cnt_q == GAP_LAST) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            gap_arm_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gap_arm_q   <= 1'b0;
      riv_q       <= 1'b0;
      rid1_q      <= '0;
      rid2_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_arm_q   <= gap_arm_d;
      riv_q       <= riv_d;
      rid1_q      <= rid1_d;
      rid2_q      <= rid2_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign root_in_valid  = riv_q;
  assign root_in_data_1 = rid1_q;
  assign root_in_data_2 = rid2_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_err        = res_err_q;
  assign busy           = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_root_dispatch.sv
// Bench for root_dispatch: behavioural root stage, issue/result scoreboard, vector table and corner sequences.
module tb_root_dispatch;
  localparam int HOLD = 2;
  localparam int GAP  = 3;
  localparam int TO   = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_data_1;
  logic [2:0]  cmd_data_2;
  logic        root_in_valid;
  logic [9:0]  root_in_data_1;
  logic [2:0]  root_in_data_2;
  logic        root_out_valid = 1'b0;
  logic [19:0] root_out_data  = '0;
  logic        res_valid;
  logic        res_ready;
  logic [19:0] res_data;
  logic        res_err;
  logic        busy;

  root_dispatch #(.FIFO_DEPTH(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data_1(cmd_data_1), .cmd_data_2(cmd_data_2),
    .root_in_valid(root_in_valid), .root_in_data_1(root_in_data_1), .root_in_data_2(root_in_data_2),
    .root_out_valid(root_out_valid), .root_out_data(root_out_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // One record drives the push, tells the root model how to answer, and holds the expected result.
  typedef struct {
    logic [9:0]  d1;
    logic [2:0]  d2;
    bit          resp;
    int          dly;
    logic [19:0] rdata;
    logic [19:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t cmd_q[$];
  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   issue_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Root model and monitor, both on the falling edge.
  int   pend = 0, pulse = 0;
  logic [19:0] pend_val = '0;
  bit   rv_prev = 0, resv_prev = 0, ov_prev = 0;
  bit   outstanding = 0, have_issue = 0, fall_seen = 0;
  int   hold_len = 0, exp_rise = 0, last_fall = 0;
  logic [9:0] iss_d1 = '0;
  logic [2:0] iss_d2 = '0;

  always @(negedge clk) begin
    vec_t c, e;
    if (pulse > 0) begin
      pulse--;
      if (pulse == 0) root_out_valid = 1'b0;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        root_out_valid = 1'b1;
        root_out_data  = pend_val;
        pulse          = 2;
      end
    end
    if (!rst_n) begin
      rv_prev = 0; resv_prev = 0; outstanding = 0; have_issue = 0; fall_seen = 0; hold_len = 0;
    end else begin
      if (ov_prev && !root_out_valid) begin
        last_fall = cyc;
        fall_seen = 1;
      end
      if (root_in_valid && !rv_prev) begin
        issue_cnt++;
        if (fall_seen) check("gap_idle_ok", (cyc - last_fall) >= GAP, 1);
        fall_seen = 0;
        hold_len  = 0;
        if (cmd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_issue: got d1=%0d with no queued command", root_in_data_1);
        end else begin
          c = cmd_q.pop_front();
          check("issue_d1", root_in_data_1, c.d1);
          check("issue_d2", root_in_data_2, c.d2);
          iss_d1 = c.d1; iss_d2 = c.d2; have_issue = 1; outstanding = 1;
          if (c.resp) begin
            pend     = c.dly;
            pend_val = c.rdata;
            exp_rise = cyc + ((c.dly > HOLD) ? c.dly : HOLD) + 1;
          end else begin
            exp_rise = cyc + HOLD + TO;
          end
        end
      end
      if (root_in_valid) hold_len++;
      if (!root_in_valid && rv_prev) begin
        check("hold_len", hold_len, HOLD);
        check("hold_data", {root_in_data_1, root_in_data_2}, {iss_d1, iss_d2});
      end
      if (res_valid && !resv_prev) begin
        if (!outstanding) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got res_valid with nothing outstanding, data %0h", res_data);
        end else begin
          check("res_latency", cyc, exp_rise);
          check("data_stable", {root_in_data_1, root_in_data_2}, {iss_d1, iss_d2});
        end
        outstanding = 0;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_accept: got data %0h with empty scoreboard", res_data);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e.exp_data);
          check("res_err", res_err, e.exp_err);
        end
      end
      rv_prev   = root_in_valid;
      resv_prev = res_valid;
    end
    ov_prev = root_out_valid;
  end

  // Inputs change only at posedge+1; a push is committed to the scoreboard if cmd_ready was high.
  task automatic try_push(input vec_t v, output bit acc);
    cmd_valid  = 1'b1;
    cmd_data_1 = v.d1;
    cmd_data_2 = v.d2;
    @(negedge clk);
    acc = cmd_ready;
    if (acc) begin
      cmd_q.push_back(v);
      exp_q.push_back(v);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push_wait(input vec_t v, input int budget);
    bit acc = 0;
    int n = 0;
    while (!acc && n < budget) begin
      try_push(v, acc);
      n++;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL push_timeout: got no acceptance of d1=%0d in %0d cycles", v.d1, budget);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && cmd_q.size() == 0 && !busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d results pending, busy=%0b; required drain in %0d cycles",
               exp_q.size(), busy, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_root_in_valid"}, root_in_valid, 0);
    check({tag, "_root_in_d1"}, root_in_data_1, 0);
    check({tag, "_root_in_d2"}, root_in_data_2, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    vec_t tbl[4];
    vec_t fill[6];
    vec_t v;
    bit   acc;
    int   base, n;

    tbl[0] = '{10'd100, 3'd2, 1'b1, 3, 20'h0A000, 20'h0A000, 1'b0};
    tbl[1] = '{10'h3FF, 3'd7, 1'b1, 1, 20'h003FF, 20'h003FF, 1'b0};
    tbl[2] = '{10'd0,   3'd0, 1'b1, 5, 20'h00000, 20'h00000, 1'b0};
    tbl[3] = '{10'd517, 3'd3, 1'b1, 2, 20'h00205, 20'h00205, 1'b0};

    fill[0] = '{10'd11,  3'd1, 1'b0, 0, 20'h0, 20'h00000, 1'b1};
    fill[1] = '{10'd22,  3'd2, 1'b1, 2, 20'h00016, 20'h00016, 1'b0};
    fill[2] = '{10'd33,  3'd3, 1'b1, 2, 20'h00021, 20'h00021, 1'b0};
    fill[3] = '{10'd44,  3'd4, 1'b1, 2, 20'h0002C, 20'h0002C, 1'b0};
    fill[4] = '{10'd55,  3'd5, 1'b1, 2, 20'h00037, 20'h00037, 1'b0};
    fill[5] = '{10'd999, 3'd6, 1'b1, 2, 20'h003E7, 20'h003E7, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data_1 = '0; cmd_data_2 = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single command first, then the rest back-to-back for ordering and gap spacing.
    for (int i = 0; i < 4; i++) push_wait(tbl[i], 200);
    wait_drain(600);
    check("table_issues", issue_cnt, 4);

    // Fill with the head command never answered.
    for (int i = 0; i < 6; i++) begin
      try_push(fill[i], acc);
      check($sformatf("fill_acc_%0d", i), acc, (i < 5) ? 1 : 0);
    end
    check("fill_ready_low", cmd_ready, 0);
    check("fill_busy", busy, 1);
    wait_drain(1500);

    // Timeout then a normal command.
    v = '{10'd77, 3'd1, 1'b0, 0, 20'h0, 20'h00000, 1'b1};
    push_wait(v, 50);
    v = '{10'd88, 3'd2, 1'b1, 4, 20'h54321, 20'h54321, 1'b0};
    push_wait(v, 50);
    wait_drain(500);

    // Backpressure holds the second issue.
    res_ready = 1'b0;
    base = issue_cnt;
    v = '{10'd301, 3'd3, 1'b1, 3, 20'h0012D, 20'h0012D, 1'b0};
    push_wait(v, 50);
    v = '{10'd302, 3'd4, 1'b1, 3, 20'h0012E, 20'h0012E, 1'b0};
    push_wait(v, 50);
    repeat (40) @(posedge clk);
    #1;
    check("bp_one_issue", issue_cnt - base, 1);
    check("bp_res_held", res_valid, 1);
    check("bp_res_data", res_data, 20'h0012D);
    res_ready = 1'b1;
    wait_drain(500);
    check("bp_two_issues", issue_cnt - base, 2);

    // Reset during WAIT with a late stage response pending.
    v = '{10'd123, 3'd5, 1'b1, 10, 20'h12345, 20'h12345, 1'b0};
    push_wait(v, 50);
    n = 0;
    while (!root_in_valid && n < 50) begin @(posedge clk); #1; n++; end
    while (root_in_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL rst_wait_timeout: got no DRIVE->WAIT transition in 50 cycles");
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cmd_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_res_valid", res_valid, 0);
    check("post_rst_busy", busy, 0);

    v = '{10'd456, 3'd6, 1'b1, 2, 20'h001C8, 20'h001C8, 1'b0};
    push_wait(v, 50);
    wait_drain(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
